picobello_boot_fixture: RTL and testbench

- Synthesizable boot/preload sequencer for the picobello top-level test fixture.
- Holds the SoC in reset and drives the boot-mode straps.
- In idle boot, triggers a preload over JTAG, serial link or UART; otherwise relies on autonomous boot.
- Polls end-of-computation (EOC), reports the exit code, then waits for the UART to go idle before signalling completion.

---
 rtl/picobello_fixture_pkg.sv | 30 +++
 rtl/picobello_fixture_cnt.sv | 17 +
 rtl/picobello_boot_fixture.sv | 117 +++++++++++
 tb/tb_picobello_boot_fixture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/picobello_fixture_pkg.sv
// picobello_fixture_pkg: shared types and helpers for the picobello boot fixture
package picobello_fixture_pkg;
  typedef enum logic [1:0] {
    BOOT_IDLE     = 2'd0,
    BOOT_SD       = 2'd1,
    BOOT_AUTO     = 2'd2,
    BOOT_AUTO_ALT = 2'd3
  } boot_mode_e;
  typedef enum logic [1:0] {
    PREL_JTAG  = 2'd0,
    PREL_SLINK = 2'd1,
    PREL_UART  = 2'd2,
    PREL_RSVD  = 2'd3
  } preload_mode_e;
  typedef enum logic [3:0] {
    S_IDLE,
    S_RST,
    S_PRELOAD,
    S_POLL_WAIT,
    S_POLL_REQ,
    S_POLL_RSP,
    S_UART_DRAIN,
    S_DONE,
    S_ERROR
  } state_e;
  localparam int unsigned EocBit = 0;
  function automatic logic [2:0] prel_onehot(input preload_mode_e m);
    return (m == PREL_RSVD) ? 3'b000 : (3'b001 << m);
  endfunction
endpackage

// File: rtl/picobello_fixture_cnt.sv
// picobello_fixture_cnt: loadable down-counter that saturates at zero
module picobello_fixture_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  assign zero_o = cnt_q == '0;
  always_ff @(posedge clk_i) begin
    cnt_q <= !rst_ni ? '0 : load_i ? val_i : (en_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
  end
endmodule

// File: rtl/picobello_boot_fixture.sv
// picobello_boot_fixture: reset, boot-strap, preload and EOC-poll sequencer for the picobello fixture
module picobello_boot_fixture
  import picobello_fixture_pkg::*;
#(
  parameter int unsigned RstCycles    = 16,
  parameter int unsigned PollInterval = 64,
  parameter int unsigned ExitW        = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       boot_mode_i,
  input  logic [1:0]       preload_mode_i,
  output logic             soc_rst_no,
  output logic [1:0]       boot_mode_o,
  output logic [2:0]       prel_req_o,
  input  logic [2:0]       prel_done_i,
  output logic             poll_req_o,
  output logic [1:0]       poll_chan_o,
  input  logic             poll_gnt_i,
  input  logic             poll_rvalid_i,
  input  logic [31:0]      poll_rdata_i,
  input  logic             uart_busy_i,
  output logic             done_o,
  output logic             error_o,
  output logic [ExitW-1:0] exit_code_o
);
  localparam int unsigned CntMax = RstCycles > PollInterval ? RstCycles : PollInterval;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  state_e        state_q;
  preload_mode_e pmode_q;
  logic          start_ok;
  logic          rsp_hit;
  logic          eoc;
  logic          to_wait;
  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_zero;
  logic [CntW-1:0] cnt_val;
  always_comb begin
    start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    rsp_hit  = poll_rvalid_i && ((state_q == S_POLL_REQ && poll_gnt_i) || state_q == S_POLL_RSP);
    eoc      = poll_rdata_i[EocBit];
    to_wait  = (state_q == S_RST && cnt_zero && boot_mode_o[1]) ||
               (state_q == S_PRELOAD && prel_done_i[pmode_q]) ||
               (rsp_hit && !eoc);
    cnt_load = start_ok || to_wait;
    cnt_en   = state_q == S_RST || state_q == S_POLL_WAIT;
    cnt_val  = start_ok ? CntW'(RstCycles - 1) : CntW'(PollInterval - 1);
  end
  picobello_fixture_cnt #(.W(CntW)) i_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pmode_q     <= PREL_JTAG;
      soc_rst_no  <= 1'b0;
      boot_mode_o <= 2'd0;
      prel_req_o  <= 3'd0;
      poll_req_o  <= 1'b0;
      poll_chan_o <= 2'd0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      exit_code_o <= '0;
    end else if (start_ok) begin
      state_q     <= S_RST;
      boot_mode_o <= boot_mode_i;
      pmode_q     <= preload_mode_e'(preload_mode_i);
      soc_rst_no  <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      exit_code_o <= '0;
    end else begin
      if (rsp_hit && eoc) exit_code_o <= ExitW'(poll_rdata_i >> 1);
      case (state_q)
        S_RST: if (cnt_zero) begin
          soc_rst_no <= 1'b1;
          if (boot_mode_o == BOOT_SD || (boot_mode_o == BOOT_IDLE && pmode_q == PREL_RSVD)) begin
            state_q <= S_ERROR;
            error_o <= 1'b1;
          end else if (boot_mode_o == BOOT_IDLE) begin
            state_q     <= S_PRELOAD;
            prel_req_o  <= prel_onehot(pmode_q);
            poll_chan_o <= pmode_q;
          end else begin
            state_q     <= S_POLL_WAIT;
            poll_chan_o <= 2'd0;
          end
        end
        S_PRELOAD: if (prel_done_i[pmode_q]) begin
          prel_req_o <= 3'd0;
          state_q    <= S_POLL_WAIT;
        end
        S_POLL_WAIT: if (cnt_zero) begin
          poll_req_o <= 1'b1;
          state_q    <= S_POLL_REQ;
        end
        S_POLL_REQ: if (poll_gnt_i) begin
          poll_req_o <= 1'b0;
          state_q    <= !rsp_hit ? S_POLL_RSP : eoc ? S_UART_DRAIN : S_POLL_WAIT;
        end
        S_POLL_RSP: if (rsp_hit) state_q <= eoc ? S_UART_DRAIN : S_POLL_WAIT;
        S_UART_DRAIN: if (!uart_busy_i) begin
          done_o  <= 1'b1;
          state_q <= S_DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_picobello_boot_fixture.sv
// tb_picobello_boot_fixture: directed runs checked every cycle against a cycle-counting reference model
module tb_picobello_boot_fixture;
  localparam int RC = 16;
  localparam int PI = 64;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  boot_mode_i = 2'd0;
  logic [1:0]  preload_mode_i = 2'd0;
  logic [2:0]  prel_done_i = 3'd0;
  logic        poll_gnt_i = 1'b0;
  logic        poll_rvalid_i = 1'b0;
  logic [31:0] poll_rdata_i = 32'd0;
  logic        uart_busy_i = 1'b0;
  logic        soc_rst_no;
  logic [1:0]  boot_mode_o;
  logic [2:0]  prel_req_o;
  logic        poll_req_o;
  logic [1:0]  poll_chan_o;
  logic        done_o;
  logic        error_o;
  logic [31:0] exit_code_o;
  always #5 clk_i = ~clk_i;
  picobello_boot_fixture #(.RstCycles(RC), .PollInterval(PI), .ExitW(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .boot_mode_i    (boot_mode_i),
    .preload_mode_i (preload_mode_i),
    .soc_rst_no     (soc_rst_no),
    .boot_mode_o    (boot_mode_o),
    .prel_req_o     (prel_req_o),
    .prel_done_i    (prel_done_i),
    .poll_req_o     (poll_req_o),
    .poll_chan_o    (poll_chan_o),
    .poll_gnt_i     (poll_gnt_i),
    .poll_rvalid_i  (poll_rvalid_i),
    .poll_rdata_i   (poll_rdata_i),
    .uart_busy_i    (uart_busy_i),
    .done_o         (done_o),
    .error_o        (error_o),
    .exit_code_o    (exit_code_o)
  );
  int total = 0;
  int passed = 0;
  bit chk_en = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  int m_ph, m_t;
  logic [1:0] m_boot, m_pre, m_chan;
  logic m_rstn, m_preq, m_done, m_err, got;
  logic [2:0] m_req;
  logic [31:0] m_exit;
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_ph = 0; m_t = 0; m_boot = 0; m_pre = 0; m_chan = 0;
      m_rstn = 0; m_preq = 0; m_done = 0; m_err = 0; m_req = 0; m_exit = 0;
    end else if (m_ph == 0 || m_ph == 7 || m_ph == 8) begin
      if (start_i) begin
        m_boot = boot_mode_i; m_pre = preload_mode_i;
        m_done = 0; m_err = 0; m_exit = 0; m_rstn = 0; m_ph = 1; m_t = 0;
      end
    end else if (m_ph == 1) begin
      m_t++;
      if (m_t == RC) begin
        m_rstn = 1;
        if (m_boot == 1 || (m_boot == 0 && m_pre == 3)) begin m_err = 1; m_ph = 8; end
        else if (m_boot == 0) begin m_req = 3'(1 << m_pre); m_chan = m_pre; m_ph = 2; end
        else begin m_chan = 0; m_ph = 3; m_t = 0; end
      end
    end else if (m_ph == 2) begin
      if (prel_done_i[m_pre]) begin m_req = 0; m_ph = 3; m_t = 0; end
    end else if (m_ph == 3) begin
      m_t++;
      if (m_t == PI) begin m_preq = 1; m_ph = 4; end
    end else if (m_ph == 4 || m_ph == 5) begin
      got = m_ph == 5 || poll_gnt_i;
      if (m_ph == 4 && poll_gnt_i) begin m_preq = 0; m_ph = 5; end
      if (got && poll_rvalid_i) begin
        if (poll_rdata_i[0]) begin m_exit = poll_rdata_i >> 1; m_ph = 6; end
        else begin m_ph = 3; m_t = 0; end
      end
    end else if (m_ph == 6) begin
      if (!uart_busy_i) begin m_done = 1; m_ph = 7; end
    end
  end
  logic [2:0] prel_seen;
  logic preq_seen;
  logic [1:0] chan_seen;
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("soc_rst_no", soc_rst_no, m_rstn);
      chk("boot_mode_o", boot_mode_o, m_boot);
      chk("prel_req_o", prel_req_o, m_req);
      chk("poll_req_o", poll_req_o, m_preq);
      chk("poll_chan_o", poll_chan_o, m_chan);
      chk("done_o", done_o, m_done);
      chk("error_o", error_o, m_err);
      chk("exit_code_o", exit_code_o, m_exit);
      prel_seen = prel_seen | prel_req_o;
      preq_seen = preq_seen | poll_req_o;
      if (poll_req_o) chan_seen = poll_chan_o;
    end
  end
  int pcnt = 0, gcnt = 0, gnt_delay = 0, prel_delay = 10;
  bit same_cycle = 0, rsp_pending = 0;
  logic [31:0] resp[$];
  task automatic next_rsp();
    poll_rvalid_i = 1;
    if (resp.size() != 0) poll_rdata_i = resp.pop_front();
    else poll_rdata_i = 32'h1;
  endtask
  initial forever begin
    @(posedge clk_i);
    #1;
    poll_gnt_i = 0;
    poll_rvalid_i = 0;
    if (prel_req_o != 0) begin
      pcnt++;
      prel_done_i = pcnt >= prel_delay ? prel_req_o : ~prel_req_o;
    end else begin
      pcnt = 0;
      prel_done_i = 0;
    end
    if (rsp_pending) begin
      next_rsp();
      rsp_pending = 0;
    end else if (poll_req_o) begin
      gcnt++;
      if (gcnt > gnt_delay) begin
        poll_gnt_i = 1;
        gcnt = 0;
        if (same_cycle) next_rsp();
        else rsp_pending = 1;
      end
    end else gcnt = 0;
  end
  task automatic run(input logic [1:0] b, input logic [1:0] p);
    prel_seen = 0; preq_seen = 0; chan_seen = 2'b11;
    boot_mode_i = b; preload_mode_i = p; start_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
  endtask
  task automatic wait_end(input string name);
    int n = 0;
    while (!(done_o || error_o) && n < 3000) begin @(posedge clk_i); #1; n++; end
    chk(name, done_o | error_o, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(posedge clk_i);
    #1;
    chk_en = 1;
    chk("reset soc_rst_no", soc_rst_no, 0);
    chk("reset done", done_o, 0);
    chk("reset exit", exit_code_o, 0);
    rst_ni = 1;
    @(posedge clk_i); #1;
    resp = '{32'h0, 32'h0, 32'h55};
    run(0, 0);
    wait_end("t1 end");
    chk("t1 prel", prel_seen, 3'b001);
    chk("t1 chan", chan_seen, 0);
    chk("t1 exit", exit_code_o, 32'h2A);
    chk("t1 done", done_o, 1);
    chk("t1 err", error_o, 0);
    same_cycle = 1; resp = '{32'h1};
    run(0, 1);
    wait_end("t2 end");
    chk("t2 prel", prel_seen, 3'b010);
    chk("t2 chan", chan_seen, 1);
    chk("t2 exit", exit_code_o, 0);
    chk("t2 done", done_o, 1);
    same_cycle = 0; gnt_delay = 3; resp = '{32'h1};
    run(0, 2);
    wait_end("t3 end");
    chk("t3 prel", prel_seen, 3'b100);
    chk("t3 chan", chan_seen, 2);
    chk("t3 done", done_o, 1);
    gnt_delay = 0;
    run(1, 0);
    n = 0;
    while (!error_o && n < 100) begin @(posedge clk_i); #1; n++; end
    chk("t4 err latency", n, RC);
    repeat (5) @(posedge clk_i); #1;
    chk("t4 err", error_o, 1);
    chk("t4 done", done_o, 0);
    chk("t4 soc_rst", soc_rst_no, 1);
    chk("t4 prel", prel_seen, 0);
    chk("t4 preq", preq_seen, 0);
    run(0, 3);
    wait_end("t5 end");
    repeat (5) @(posedge clk_i); #1;
    chk("t5 err", error_o, 1);
    chk("t5 prel", prel_seen, 0);
    chk("t5 preq", preq_seen, 0);
    resp = '{32'hFFFF_FFFF};
    run(2, 0);
    wait_end("t6 end");
    chk("t6 prel", prel_seen, 0);
    chk("t6 chan", chan_seen, 0);
    chk("t6 exit", exit_code_o, 32'h7FFF_FFFF);
    chk("t6 done", done_o, 1);
    uart_busy_i = 1; resp = '{32'h3};
    run(3, 0);
    n = 0;
    while (exit_code_o != 1 && n < 500) begin @(posedge clk_i); #1; n++; end
    chk("t7 eoc", exit_code_o, 1);
    repeat (20) @(posedge clk_i); #1;
    chk("t7 busy hold", done_o, 0);
    uart_busy_i = 0;
    @(posedge clk_i); #1;
    chk("t7 done edge", done_o, 1);
    gnt_delay = 100000; prel_delay = 2; resp.delete();
    run(0, 2);
    n = 0;
    while (!poll_req_o && n < 500) begin @(posedge clk_i); #1; n++; end
    chk("t8 poll req", poll_req_o, 1);
    chk("t8 chan pre", poll_chan_o, 2);
    repeat (2) @(posedge clk_i); #1;
    rst_ni = 0;
    @(posedge clk_i); #1;
    chk("t8 rst soc", soc_rst_no, 0);
    chk("t8 rst preq", poll_req_o, 0);
    chk("t8 rst chan", poll_chan_o, 0);
    chk("t8 rst prel", prel_req_o, 0);
    chk("t8 rst done", done_o, 0);
    chk("t8 rst err", error_o, 0);
    rst_ni = 1; gnt_delay = 0; prel_delay = 10; resp = '{32'h55};
    @(posedge clk_i); #1;
    run(2, 0);
    wait_end("t8 end");
    chk("t8 exit", exit_code_o, 32'h2A);
    chk("t8 done", done_o, 1);
    @(negedge clk_i);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
